// File: rtl/ex_fu_scheduler.sv
// ex_fu_scheduler: round-robin issue select for the shared execute datapath.
// It keeps one shared writeback slot conflict-free across single-cycle ALU and
// branch ops, MULT_LAT-cycle multiplies and variable-latency loads.
// Optional feature: define SCHED_PERF_EN to add the stall_cycles counter port.
// The reset input is active-low and asynchronous.
module ex_fu_scheduler #(
    parameter int unsigned NUM_REQ  = 8,
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned IDX_W    = $clog2(NUM_REQ)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [2*NUM_REQ-1:0] req_class,
    input  logic                 load_done,
    input  logic                 flush,
    output logic                 grant_valid,
    output logic [IDX_W-1:0]     grant_idx,
    output logic [1:0]           grant_class,
    output logic                 wb_valid,
    output logic [1:0]           wb_class,
    output logic                 load_busy,
    output logic [3:0]           mult_inflight
`ifdef SCHED_PERF_EN
    ,
    output logic [31:0]          stall_cycles
`endif
);

    typedef enum logic [1:0] {
        CLS_ALU    = 2'b00,
        CLS_MULT   = 2'b01,
        CLS_LOAD   = 2'b10,
        CLS_BRANCH = 2'b11
    } fu_class_t;

    typedef enum logic [1:0] {
        LD_IDLE = 2'b00,
        LD_WAIT = 2'b01,
        LD_HOLD = 2'b10
    } ld_state_t;

    // Writeback slot pipe: entry k completes k cycles from now.
    logic [MULT_LAT-1:0] w_v;
    logic [1:0]          w_cls     [MULT_LAT];
    logic [MULT_LAT-1:0] w_v_nxt;
    logic [1:0]          w_cls_nxt [MULT_LAT];

    ld_state_t           ld_state, ld_state_nxt;
    logic [IDX_W-1:0]    rr_ptr;
    logic [3:0]          mult_cnt, mult_cnt_nxt;

    logic [1:0]          req_cls [NUM_REQ];
    logic [NUM_REQ-1:0]  elig;
    logic                found;
    logic [IDX_W-1:0]    sel;
    logic                load_commit;
    logic                grant_mult;
    logic                wb_mult;

    // A held load takes the slot as soon as nothing else is due there next cycle.
    assign load_commit = (ld_state == LD_HOLD) && !w_v[1];

    // Per-entry eligibility from class and current slot / load occupancy.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_cls[i] = req_class[2*i +: 2];
            elig[i]    = 1'b0;
            if (req_valid[i]) begin
                case (fu_class_t'(req_cls[i]))
                    CLS_MULT: elig[i] = 1'b1;
                    CLS_LOAD: elig[i] = (ld_state == LD_IDLE);
                    default:  elig[i] = !w_v[1] && !load_commit;
                endcase
            end
        end
    end

    // Round-robin search for the first eligible entry starting at rr_ptr.
    always_comb begin : arb
        logic [IDX_W:0] cand;
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(off);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!found && elig[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                sel   = cand[IDX_W-1:0];
            end
        end
    end

    // Grant outputs; forced quiet during reset and on a flush cycle.
    always_comb begin
        grant_valid = found && !flush && reset;
        grant_idx   = grant_valid ? sel : '0;
        grant_class = grant_valid ? req_cls[sel] : 2'b00;
    end

    assign grant_mult = grant_valid && (grant_class == CLS_MULT);
    assign wb_mult    = w_v[0] && (w_cls[0] == CLS_MULT);

    // Next slot pipe: shift toward W[0], then overlay this cycle's reservation.
    always_comb begin
        for (int unsigned k = 0; k < MULT_LAT - 1; k++) begin
            w_v_nxt[k]   = w_v[k+1];
            w_cls_nxt[k] = w_cls[k+1];
        end
        w_v_nxt[MULT_LAT-1]   = 1'b0;
        w_cls_nxt[MULT_LAT-1] = 2'b00;
        if (grant_valid) begin
            case (fu_class_t'(grant_class))
                CLS_MULT: begin
                    w_v_nxt[MULT_LAT-1]   = 1'b1;
                    w_cls_nxt[MULT_LAT-1] = CLS_MULT;
                end
                CLS_LOAD: ;
                default: begin
                    w_v_nxt[0]   = 1'b1;
                    w_cls_nxt[0] = grant_class;
                end
            endcase
        end
        if (load_commit) begin
            w_v_nxt[0]   = 1'b1;
            w_cls_nxt[0] = CLS_LOAD;
        end
        if (flush) begin
            w_v_nxt = '0;
            for (int unsigned k = 0; k < MULT_LAT; k++) begin
                w_cls_nxt[k] = 2'b00;
            end
        end
    end

    // Load FSM next state; flush returns it to IDLE and drops any load_done.
    always_comb begin
        ld_state_nxt = ld_state;
        case (ld_state)
            LD_IDLE: if (grant_valid && grant_class == CLS_LOAD) ld_state_nxt = LD_WAIT;
            LD_WAIT: if (load_done) ld_state_nxt = LD_HOLD;
            LD_HOLD: if (!w_v[1]) ld_state_nxt = LD_IDLE;
            default: ld_state_nxt = LD_IDLE;
        endcase
        if (flush) ld_state_nxt = LD_IDLE;
    end

    // In-flight multiply count: grants in, MULT writebacks out.
    always_comb begin
        mult_cnt_nxt = mult_cnt + {3'b000, grant_mult} - {3'b000, wb_mult};
        if (flush) mult_cnt_nxt = '0;
    end

    // Slot pipe register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            w_v <= '0;
            for (int unsigned k = 0; k < MULT_LAT; k++) begin
                w_cls[k] <= 2'b00;
            end
        end else begin
            w_v <= w_v_nxt;
            for (int unsigned k = 0; k < MULT_LAT; k++) begin
                w_cls[k] <= w_cls_nxt[k];
            end
        end
    end

    // Load FSM state, round-robin pointer and multiply count registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ld_state <= LD_IDLE;
            rr_ptr   <= '0;
            mult_cnt <= '0;
        end else begin
            ld_state <= ld_state_nxt;
            mult_cnt <= mult_cnt_nxt;
            if (grant_valid) begin
                rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
            end
        end
    end

    assign wb_valid      = w_v[0];
    assign wb_class      = w_v[0] ? w_cls[0] : 2'b00;
    assign load_busy     = (ld_state != LD_IDLE);
    assign mult_inflight = mult_cnt;

`ifdef SCHED_PERF_EN
    // Saturating count of cycles with ready work but no issue (flush excluded).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if ((|req_valid) && !grant_valid && !flush && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_fu_scheduler.sv
// Directed bench for ex_fu_scheduler with a time-indexed completion model.
// The model books writebacks by absolute cycle number and derives every
// expected output from those bookings; literal pins fix key cycles.
module tb_ex_fu_scheduler;

    localparam int NR = 8;
    localparam int ML = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  req_valid = '0;
    logic [15:0] req_class = '0;
    logic        load_done = 1'b0;
    logic        flush = 1'b0;
    logic        grant_valid;
    logic [2:0]  grant_idx;
    logic [1:0]  grant_class;
    logic        wb_valid;
    logic [1:0]  wb_class;
    logic        load_busy;
    logic [3:0]  mult_inflight;
`ifdef SCHED_PERF_EN
    logic [31:0] stall_cycles;
`endif

    ex_fu_scheduler #(.NUM_REQ(NR), .MULT_LAT(ML)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_class(req_class),
        .load_done(load_done), .flush(flush), .grant_valid(grant_valid),
        .grant_idx(grant_idx), .grant_class(grant_class), .wb_valid(wb_valid),
        .wb_class(wb_class), .load_busy(load_busy), .mult_inflight(mult_inflight)
`ifdef SCHED_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: sched[t] = class completing at cycle t, -1 when free.
    int sched [0:511];
    int m_rr, m_ld, cyc;
    longint m_stall;
    int mlog [6][64];
    int dlog [6][64];

    localparam int F_GV = 0, F_GI = 1, F_WBV = 2, F_WBC = 3, F_INF = 4, F_BUSY = 5;

    function automatic logic [15:0] cls_at(input int i, input int c);
        logic [15:0] v;
        v = 16'(c);
        return v << (2*i);
    endfunction

    task automatic chk(input string nm, input int c, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, c, act, exp);
        end
    endtask

    task automatic pin(input string nm, input int c, input int f, input int lit);
        chk({nm, " model"}, c, mlog[f][c], lit);
        chk({nm, " dut"},   c, dlog[f][c], lit);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_valid = 8'hFF; req_class = '0; load_done = 1'b0; flush = 1'b0;
        #1;
        chk("rst grant_valid", -1, grant_valid, 0);
        chk("rst grant_idx",   -1, grant_idx, 0);
        chk("rst grant_class", -1, grant_class, 0);
        chk("rst wb_valid",    -1, wb_valid, 0);
        chk("rst load_busy",   -1, load_busy, 0);
        chk("rst mult_inflight", -1, mult_inflight, 0);
`ifdef SCHED_PERF_EN
        chk("rst stall_cycles", -1, stall_cycles, 0);
`endif
        for (int k = 0; k < 512; k++) sched[k] = -1;
        for (int f = 0; f < 6; f++) for (int k = 0; k < 64; k++) begin
            mlog[f][k] = -1; dlog[f][k] = -1;
        end
        m_rr = 0; m_ld = 0; cyc = 0; m_stall = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // One cycle: drive inputs, compare against the model, advance the model.
    task automatic step(input logic [7:0] rv, input logic [15:0] rc, input bit ld, input bit fl);
        int e_gv, e_gi, e_gc, e_wbv, e_wbc, e_inf, e_busy, old_ld, c, i;
        bit commit;
        req_valid = rv; req_class = rc; load_done = ld; flush = fl;
        #3;
        commit = (m_ld == 2) && (sched[cyc+1] < 0);
        e_gv = 0; e_gi = 0; e_gc = 0;
        if (!fl) begin
            for (int off = 0; off < NR; off++) begin
                i = (m_rr + off) % NR;
                c = int'((rc >> (2*i)) & 16'h3);
                if (rv[i] && e_gv == 0) begin
                    if (c == 1 || (c == 2 && m_ld == 0) ||
                        ((c == 0 || c == 3) && sched[cyc+1] < 0 && !commit)) begin
                        e_gv = 1; e_gi = i; e_gc = c;
                    end
                end
            end
        end
        e_wbv = (sched[cyc] >= 0) ? 1 : 0;
        e_wbc = e_wbv ? sched[cyc] : 0;
        e_inf = 0;
        for (int k = cyc; k <= cyc + ML; k++) if (sched[k] == 1) e_inf++;
        e_busy = (m_ld != 0) ? 1 : 0;

        chk("grant_valid", cyc, grant_valid, e_gv);
        chk("grant_idx",   cyc, grant_idx, e_gi);
        chk("grant_class", cyc, grant_class, e_gc);
        chk("wb_valid",    cyc, wb_valid, e_wbv);
        chk("wb_class",    cyc, wb_class, e_wbc);
        chk("load_busy",   cyc, load_busy, e_busy);
        chk("mult_inflight", cyc, mult_inflight, e_inf);
`ifdef SCHED_PERF_EN
        chk("stall_cycles", cyc, stall_cycles, m_stall);
`endif
        if (cyc < 64) begin
            mlog[F_GV][cyc] = e_gv;  dlog[F_GV][cyc] = int'(grant_valid);
            mlog[F_GI][cyc] = e_gi;  dlog[F_GI][cyc] = int'(grant_idx);
            mlog[F_WBV][cyc] = e_wbv; dlog[F_WBV][cyc] = int'(wb_valid);
            mlog[F_WBC][cyc] = e_wbc; dlog[F_WBC][cyc] = int'(wb_class);
            mlog[F_INF][cyc] = e_inf; dlog[F_INF][cyc] = int'(mult_inflight);
            mlog[F_BUSY][cyc] = e_busy; dlog[F_BUSY][cyc] = int'(load_busy);
        end

        if (rv != 0 && e_gv == 0 && !fl && m_stall < 64'hFFFF_FFFF) m_stall++;
        old_ld = m_ld;
        if (fl) begin
            for (int k = cyc + 1; k <= cyc + ML + 1; k++) sched[k] = -1;
            m_ld = 0;
        end else begin
            if (e_gv) begin
                m_rr = (e_gi + 1) % NR;
                if (e_gc == 1) sched[cyc+ML] = 1;
                else if (e_gc == 2) m_ld = 1;
                else sched[cyc+1] = e_gc;
            end
            if (commit) begin
                sched[cyc+1] = 2;
                m_ld = 0;
            end else if (old_ld == 1 && ld) begin
                m_ld = 2;
            end
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    initial begin
        // Single ALU issue and its writeback one cycle later.
        do_reset();
        step(8'h01, cls_at(0, 0), 0, 0);
        step(8'h00, '0, 0, 0);
        step(8'h00, '0, 0, 0);
        pin("t1 gv", 0, F_GV, 1);
        pin("t1 gi", 0, F_GI, 0);
        pin("t1 wbv", 1, F_WBV, 1);
        pin("t1 wbc", 1, F_WBC, 0);

        // MULT blocks a later ALU from colliding at its writeback cycle.
        do_reset();
        step(8'h04, cls_at(2, 1), 0, 0);
        step(8'h00, '0, 0, 0);
        step(8'h00, '0, 0, 0);
        step(8'h08, cls_at(3, 0), 0, 0);
        step(8'h08, cls_at(3, 0), 0, 0);
        step(8'h00, '0, 0, 0);
        step(8'h00, '0, 0, 0);
        pin("t2 gv c3", 3, F_GV, 0);
        pin("t2 gv c4", 4, F_GV, 1);
        pin("t2 gi c4", 4, F_GI, 3);
        pin("t2 wbc c4", 4, F_WBC, 1);
        pin("t2 wbc c5", 5, F_WBC, 0);
        pin("t2 wbv c5", 5, F_WBV, 1);
        pin("t2 inf c1", 1, F_INF, 1);
        pin("t2 inf c4", 4, F_INF, 1);
        pin("t2 inf c5", 5, F_INF, 0);

        // All entries request ALU: strict rotation, slot busy every cycle.
        do_reset();
        for (int k = 0; k < 10; k++) step(8'hFF, '0, 0, 0);
        for (int k = 0; k < 9; k++) pin("t3 gi", k, F_GI, k % 8);
        for (int k = 1; k < 10; k++) pin("t3 wbv", k, F_WBV, 1);

        // Load lifecycle: WAIT, HOLD with commit priority, then next load.
        do_reset();
        step(8'h20, cls_at(5, 2), 0, 0);
        step(8'h42, cls_at(6, 2), 0, 0);
        step(8'h42, cls_at(6, 2), 0, 0);
        step(8'h42, cls_at(6, 2), 1, 0);
        step(8'h42, cls_at(6, 2), 0, 0);
        step(8'h42, cls_at(6, 2), 0, 0);
        step(8'h02, '0, 0, 0);
        pin("t4 gi c1", 1, F_GI, 1);
        pin("t4 busy c1", 1, F_BUSY, 1);
        pin("t4 busy c4", 4, F_BUSY, 1);
        pin("t4 gv c4", 4, F_GV, 0);
        pin("t4 wbv c5", 5, F_WBV, 1);
        pin("t4 wbc c5", 5, F_WBC, 2);
        pin("t4 gi c5", 5, F_GI, 6);
        pin("t4 busy c5", 5, F_BUSY, 0);
        pin("t4 busy c6", 6, F_BUSY, 1);

        // Flush squashes two in-flight multiplies.
        do_reset();
        step(8'h01, cls_at(0, 1), 0, 0);
        step(8'h02, cls_at(1, 1), 0, 0);
        step(8'h04, cls_at(2, 0), 0, 1);
        for (int k = 0; k < 5; k++) step(8'h00, '0, 0, 0);
        pin("t5 inf c2", 2, F_INF, 2);
        pin("t5 gv c2", 2, F_GV, 0);
        pin("t5 inf c3", 3, F_INF, 0);
        for (int k = 2; k <= 6; k++) pin("t5 wbv", k, F_WBV, 0);

        // Flush together with load_done drops the load; load_done in IDLE ignored.
        do_reset();
        step(8'h01, cls_at(0, 2), 0, 0);
        step(8'h00, '0, 0, 0);
        step(8'h00, '0, 1, 1);
        step(8'h00, '0, 1, 0);
        step(8'h00, '0, 0, 0);
        pin("t7 busy c2", 2, F_BUSY, 1);
        pin("t7 busy c3", 3, F_BUSY, 0);
        pin("t7 busy c4", 4, F_BUSY, 0);
        pin("t7 wbv c4", 4, F_WBV, 0);

        // Asynchronous reset while a load waits and an ALU writeback is due.
        do_reset();
        step(8'h01, cls_at(0, 2), 0, 0);
        step(8'h00, '0, 0, 0);
        step(8'h02, cls_at(1, 0), 0, 0);
        req_valid = 8'hFF; req_class = '0;
        #1;
        chk("t6 pre busy", cyc, load_busy, 1);
        chk("t6 pre wbv",  cyc, wb_valid, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("t6 async busy", cyc, load_busy, 0);
        chk("t6 async wbv",  cyc, wb_valid, 0);
        chk("t6 async gv",   cyc, grant_valid, 0);
`ifdef SCHED_PERF_EN
        chk("t6 async stall", cyc, stall_cycles, 0);
`endif
        do_reset();
        step(8'h00, '0, 1, 0);
        step(8'h00, '0, 1, 0);
        step(8'h00, '0, 0, 0);
        pin("t6 busy c1", 1, F_BUSY, 0);
        pin("t6 busy c2", 2, F_BUSY, 0);
        pin("t6 wbv c2", 2, F_WBV, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
